serial_addsub_ctrl: RTL and testbench
=====================================

// Module: serial_addsub_ctrl
// PURPOSE
//  Nibble-serial add/subtract sequencer for WIDTH-bit operands.
//  Reuses one 4-bit carry_select_adder slice (ports a, b, c_in, sum, c_out) over WIDTH/4 cycles, LSB nibble first.
//  For subtracts it returns sign+magnitude: when a<b, a second serial pass two's-complements the raw difference.
//  Sits between the operand-issuing control logic and the result consumer; valid/ready on both sides.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of 4 and >= 8 (NIB = WIDTH/4)
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      synchronous active-low reset
//  start_valid   in   1      operands/op valid
//  start_ready   out  1      controller can accept (high only in IDLE)
//  op            in   1      0 = a+b, 1 = a-b
//  a             in   WIDTH  operand A, unsigned
//  b             in   WIDTH  operand B, unsigned
//  result_valid  out  1      result/flags valid (high only in DONE)
//  result_ready  in   1      consumer accepts result
//  result        out  WIDTH  add: a+b mod 2^WIDTH; sub: |a-b|
//  carry_out     out  1      add: carry out of MSB; sub: 1 = no borrow (a>=b)
//  neg           out  1      sub only: 1 when a<b; always 0 for add
//  busy          out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; result, carry_out, neg, result_valid, busy = 0; start_ready = 1 after reset.
//  FSM states and transitions:
//   IDLE: start_ready=1; on start_valid, latch a, b, op; set nibble count=0 -> RUN.
//         For op=1, latch ~b and set carry_reg=1; for op=0, latch b and set carry_reg=0.
//   RUN:  each cycle, apply slice: a_nib[i] + b_nib[i] + carry_reg.
//         sum written to result nibble i; carry_reg <= c_out; i++.
//         After nibble NIB-1: carry_out <= final c_out.
//         If op=1 and final c_out=0: neg <= 1 -> FIX; otherwise -> DONE.
//   FIX:  i restarts at 0, carry_reg=1; each cycle, slice a = ~result_nib[i], b = 4'h0.
//         result nibble i <= sum; after NIB cycles -> DONE.
//   DONE: result_valid=1; result, carry_out, neg held stable.
//         On result_ready -> IDLE; result_valid drops next cycle. Outputs keep their values until the next accept.
//  Latency (edge of accept = E0): result_valid high after E(NIB); subtract with a<b: after E(2*NIB).
//  Throughput: one op per NIB+2 cycles min (accept, NIB RUN, one DONE cycle with ready=1).
//   A new start is not taken in the same cycle as the result handshake.
//  Boundary rules:
//   start_valid while busy: ignored (start_ready=0); operands are not re-sampled mid-op.
//   Sub a==b: result=0, carry_out=1, neg=0, no FIX pass.
//   Add overflow: result wraps, carry_out=1.
//   Sub a=0, b=2^WIDTH-1: result=2^WIDTH-1, neg=1.
//   result_ready low in DONE: hold indefinitely, no output changes.
//   result_ready high outside DONE: no effect.
//   rst_n low in any state (incl. mid RUN/FIX): abort; outputs and flags clear at that edge; op is discarded.
//   Arithmetic is unsigned throughout; no X propagation from unused operand bits.
// TESTING (WIDTH=16)
//  1. add 0x1234+0x0FFF -> result 0x2233, carry_out 0, neg 0; result_valid 4 edges after accept.
//  2. add 0xFFFF+0x0001 -> result 0x0000, carry_out 1, neg 0.
//  3. sub 0x5000-0x1234 -> result 0x3DCC, carry_out 1, neg 0, valid after 4 edges.
//     sub 0x7777-0x7777 -> result 0, carry_out 1, neg 0.
//  4. sub 0x0003-0x0010 -> result 0x000D, carry_out 0, neg 1, valid after 8 edges.
//     sub 0x0000-0xFFFF -> result 0xFFFF, neg 1.
//  5. Backpressure: hold result_ready=0 for 5 cycles in DONE while driving start_valid=1.
//     -> result/flags stable, start_ready=0.
//     Raise ready -> IDLE next cycle; the pending start is accepted the cycle after.
//  6. Assert rst_n=0 on 2nd RUN cycle of a sub.
//     -> all outputs 0 next cycle; start_ready=1 after release.
//     A fresh add 0x0001+0x0001 then yields 0x0002.

Source files
------------

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - nibble-serial add/subtract sequencer with sign+magnitude subtract result

module carry_select_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [4:0] sum0;
    logic [4:0] sum1;

    // Both carry-in cases are formed up front and c_in only picks one.
    assign sum0  = {1'b0, a} + {1'b0, b};
    assign sum1  = {1'b0, a} + {1'b0, b} + 5'd1;
    assign sum   = c_in ? sum1[3:0] : sum0[3:0];
    assign c_out = c_in ? sum1[4]   : sum0[4];
endmodule

module serial_addsub_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             neg,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             op_reg;
    logic             carry_reg;
    logic [IW-1:0]    idx;

    logic [3:0] a_nibs   [NIB];
    logic [3:0] b_nibs   [NIB];
    logic [3:0] res_nibs [NIB];

    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_sum;
    logic       slice_cout;

    logic accept;
    logic last_nib;
    logic need_fix;

    always_comb begin
        for (int k = 0; k < NIB; k++) begin
            a_nibs[k]   = a_reg[k*4 +: 4];
            b_nibs[k]   = b_reg[k*4 +: 4];
            res_nibs[k] = result[k*4 +: 4];
        end
    end

    carry_select_adder u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_reg),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    assign accept   = (state == IDLE) && start_valid;
    assign last_nib = (idx == LAST);
    // A subtract with no carry out of the MSB borrowed, so the raw difference must be negated.
    assign need_fix = op_reg && !slice_cout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_valid)  state_next = RUN;
            RUN:  if (last_nib)     state_next = need_fix ? FIX : DONE;
            FIX:  if (last_nib)     state_next = DONE;
            DONE: if (result_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        start_ready  = (state == IDLE);
        result_valid = (state == DONE);
        busy         = (state != IDLE);
        slice_a      = a_nibs[idx];
        slice_b      = b_nibs[idx];
        if (state == FIX) begin
            slice_a = ~res_nibs[idx];
            slice_b = 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            neg       <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= op ? ~b : b;
            op_reg    <= op;
            carry_reg <= op;
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            neg       <= 1'b0;
        end else if (state == RUN || state == FIX) begin
            for (int k = 0; k < NIB; k++) begin
                if (idx == IW'(k)) begin
                    result[k*4 +: 4] <= slice_sum;
                end
            end
            carry_reg <= slice_cout;
            idx       <= idx + 1'b1;
            if (last_nib) begin
                idx <= '0;
                if (state == RUN) begin
                    carry_out <= slice_cout;
                    if (need_fix) begin
                        neg       <= 1'b1;
                        carry_reg <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - directed and randomized checks of serial_addsub_ctrl against an arithmetic model

module tb_serial_addsub_ctrl;
    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             neg;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .carry_out    (carry_out),
        .neg          (neg),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer arithmetic, subtract reported as sign + magnitude.
    task automatic model(input logic op_i, input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                         output logic [WIDTH-1:0] r, output logic c, output logic n, output int lat);
        int unsigned s;
        if (!op_i) begin
            s   = int'(a_i) + int'(b_i);
            r   = s[WIDTH-1:0];
            c   = s[WIDTH];
            n   = 1'b0;
            lat = WIDTH / 4;
        end else if (a_i >= b_i) begin
            r   = a_i - b_i;
            c   = 1'b1;
            n   = 1'b0;
            lat = WIDTH / 4;
        end else begin
            r   = b_i - a_i;
            c   = 1'b0;
            n   = 1'b1;
            lat = 2 * (WIDTH / 4);
        end
    endtask

    // Issue one op, count edges until result_valid, compare with the model, then hand the result off.
    task automatic run_op(input string tag, input logic op_i, input logic [WIDTH-1:0] a_i,
                          input logic [WIDTH-1:0] b_i, input int ready_delay);
        logic [WIDTH-1:0] r_exp;
        logic             c_exp;
        logic             n_exp;
        int               lat_exp;
        int               lat;
        model(op_i, a_i, b_i, r_exp, c_exp, n_exp, lat_exp);
        chk({tag, " start_ready"}, 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        op          = op_i;
        a           = a_i;
        b           = b_i;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a           = $urandom;
        b           = $urandom;
        op          = 1'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (result_valid) break;
        end
        chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
        chk({tag, " result"}, 32'(result), 32'(r_exp));
        chk({tag, " carry_out"}, 32'(carry_out), 32'(c_exp));
        chk({tag, " neg"}, 32'(neg), 32'(n_exp));
        repeat (ready_delay) @(posedge clk);
        #1;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk({tag, " valid drop"}, 32'(result_valid), 32'd0);
        chk({tag, " result kept"}, 32'(result), 32'(r_exp));
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        logic             held_c;
        logic             held_n;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rop;

        rst_n        = 1'b0;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        op           = 1'b0;
        a            = '0;
        b            = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset start_ready", 32'(start_ready), 32'd1);
        chk("reset result_valid", 32'(result_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset carry_out", 32'(carry_out), 32'd0);
        chk("reset neg", 32'(neg), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add_basic", 1'b0, 16'h1234, 16'h0FFF, 0);
        run_op("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 1);
        run_op("sub_pos", 1'b1, 16'h5000, 16'h1234, 0);
        run_op("sub_equal", 1'b1, 16'h7777, 16'h7777, 0);
        run_op("sub_neg", 1'b1, 16'h0003, 16'h0010, 2);
        run_op("sub_neg_max", 1'b1, 16'h0000, 16'hFFFF, 0);

        // Backpressure in DONE with a competing start pending.
        start_valid = 1'b1;
        op          = 1'b0;
        a           = 16'h00A0;
        b           = 16'h000B;
        @(posedge clk);
        #1;
        a = 16'h1111;
        b = 16'h2222;
        op = 1'b1;
        for (int i = 0; i < 40 && !result_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("bp valid", 32'(result_valid), 32'd1);
        held   = result;
        held_c = carry_out;
        held_n = neg;
        chk("bp result", 32'(held), 32'h00AB);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp hold valid", 32'(result_valid), 32'd1);
            chk("bp hold start_ready", 32'(start_ready), 32'd0);
            chk("bp hold result", 32'({held_c, held_n, result}), 32'({held_c, held_n, held}));
            chk("bp hold flags", 32'({carry_out, neg}), 32'({held_c, held_n}));
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk("bp idle valid", 32'(result_valid), 32'd0);
        chk("bp idle start_ready", 32'(start_ready), 32'd1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        chk("bp pending accepted", 32'(busy), 32'd1);
        for (int i = 0; i < 40 && !result_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("bp pending result", 32'(result), 32'h1111);
        chk("bp pending neg", 32'(neg), 32'd1);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;

        // Reset during the second RUN cycle of a subtract.
        start_valid = 1'b1;
        op          = 1'b1;
        a           = 16'h0003;
        b           = 16'h0010;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort outputs", 32'({result_valid, carry_out, neg, result}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort start_ready", 32'(start_ready), 32'd1);
        run_op("after_abort", 1'b0, 16'h0001, 16'h0001, 0);

        for (int i = 0; i < 24; i++) begin
            ra  = WIDTH'($urandom);
            rb  = (i % 6 == 0) ? ra : WIDTH'($urandom);
            rop = 1'($urandom);
            run_op("random", rop, ra, rb, int'($urandom_range(0, 3)));
        end

        // Ready outside DONE must not disturb an idle controller.
        result_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk("stray ready busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
